weight_tile_packer: RTL and testbench

- Upstream feeder for the GEMV tile engine.
- Accepts a packed row-major int8 weight stream, IN_BYTES elements per beat, and re-slices it into row-aligned tiles of TILE_SIZE elements.
- Zero-pads the last tile of each row and presents tiles on a valid/ready handshake matching the engine's w_valid/w_ready/w_tile_row_in.
- Double-buffered: one assembly buffer and one output register, so a new tile packs while the previous tile waits for acceptance.

---
 rtl/weight_tile_packer.sv | 182 ++++++++++++++++++
 tb/tb_weight_tile_packer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/weight_tile_packer.sv
// rtl/weight_tile_packer.sv - re-slices a packed int8 weight stream into row-aligned, zero-padded tiles
// Optional WEIGHT_TILE_PACKER_PERF_EN adds stall_cycles/starve_cycles counters.
module weight_tile_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_SIZE  = 32,
    parameter int IN_BYTES   = 8,
    parameter int DIM_WIDTH  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [DIM_WIDTH-1:0]           rows,
    input  logic [DIM_WIDTH-1:0]           cols,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_BYTES*DATA_WIDTH-1:0] in_data,
    output logic                           w_valid,
    input  logic                           w_ready,
    output logic signed [DATA_WIDTH-1:0]   w_tile [0:TILE_SIZE-1],
    output logic                           busy,
    output logic                           done
`ifdef WEIGHT_TILE_PACKER_PERF_EN
    ,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    starve_cycles
`endif
);
    localparam int PW = $clog2(IN_BYTES + 1);
    localparam int FW = $clog2(TILE_SIZE + 1);
    localparam int NW = ((FW > DIM_WIDTH) ? FW : DIM_WIDTH) + 1;
    localparam int EW = 2 * DIM_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                         state;
    logic [DIM_WIDTH-1:0]           rows_q, cols_q, row_cnt, col_cnt;
    logic [EW-1:0]                  fetch_left;
    logic [IN_BYTES*DATA_WIDTH-1:0] beat_q;
    logic [PW-1:0]                  ptr;
    logic                           buf_full;
    logic [FW-1:0]                  fill;
    logic [DATA_WIDTH-1:0]          asm_q     [0:TILE_SIZE-1];
    logic [DATA_WIDTH-1:0]          asm_next  [0:TILE_SIZE-1];
    logic [DATA_WIDTH-1:0]          seal_tile [0:TILE_SIZE-1];

    logic [NW-1:0] left_beat, left_tile, left_row, n, new_fill, new_ptr, new_col;
    logic          row_end, last_row, seal, out_free, step_en, beat_empties, in_fire;

    always_comb begin
        left_beat = NW'(IN_BYTES) - NW'(ptr);
        left_tile = NW'(TILE_SIZE) - NW'(fill);
        left_row  = NW'(cols_q) - NW'(col_cnt);
        n = left_beat;
        if (left_tile < n) n = left_tile;
        if (left_row < n)  n = left_row;
        new_fill = NW'(fill) + n;
        new_ptr  = NW'(ptr) + n;
        new_col  = NW'(col_cnt) + n;
        row_end  = (new_col == NW'(cols_q));
        last_row = row_end && ((row_cnt + DIM_WIDTH'(1)) == rows_q);
        seal     = row_end || (new_fill == NW'(TILE_SIZE));
        out_free = !w_valid || w_ready;
        // A seal that cannot reach the output register freezes the whole step.
        step_en      = (state == S_RUN) && buf_full && (!seal || out_free);
        beat_empties = step_en && (new_ptr == NW'(IN_BYTES));
        in_ready     = (state == S_RUN) && (fetch_left != '0) && (!buf_full || beat_empties);
        in_fire      = in_valid && in_ready;
        for (int i = 0; i < TILE_SIZE; i++) begin
            asm_next[i] = asm_q[i];
            for (int k = 0; k < IN_BYTES; k++) begin
                if ((NW'(k) >= NW'(ptr)) && (NW'(k) < new_ptr) &&
                    (NW'(i) == NW'(fill) + NW'(k) - NW'(ptr)))
                    asm_next[i] = beat_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
            seal_tile[i] = (NW'(i) < new_fill) ? asm_next[i] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_cnt    <= '0;
            col_cnt    <= '0;
            fetch_left <= '0;
            beat_q     <= '0;
            ptr        <= '0;
            buf_full   <= 1'b0;
            fill       <= '0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                asm_q[i]  <= '0;
                w_tile[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (w_valid && w_ready)
                w_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows_q     <= rows;
                        cols_q     <= cols;
                        row_cnt    <= '0;
                        col_cnt    <= '0;
                        fill       <= '0;
                        ptr        <= '0;
                        buf_full   <= 1'b0;
                        fetch_left <= EW'(rows) * EW'(cols);
                        if (rows == '0 || cols == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (step_en) begin
                        ptr     <= PW'(new_ptr);
                        fill    <= FW'(new_fill);
                        col_cnt <= DIM_WIDTH'(new_col);
                        asm_q   <= asm_next;
                        if (beat_empties)
                            buf_full <= 1'b0;
                        if (seal) begin
                            for (int i = 0; i < TILE_SIZE; i++)
                                w_tile[i] <= $signed(seal_tile[i]);
                            w_valid <= 1'b1;
                            fill    <= '0;
                            if (row_end) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + DIM_WIDTH'(1);
                            end
                            // Bytes beyond the matrix in the final beat are dropped here.
                            if (last_row) begin
                                state    <= S_DRAIN;
                                buf_full <= 1'b0;
                            end
                        end
                    end
                    if (in_fire) begin
                        beat_q     <= in_data;
                        ptr        <= '0;
                        buf_full   <= 1'b1;
                        fetch_left <= (fetch_left > EW'(IN_BYTES)) ? fetch_left - EW'(IN_BYTES) : '0;
                    end
                end
                S_DRAIN: begin
                    if (!w_valid || w_ready) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WEIGHT_TILE_PACKER_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else begin
            if (w_valid && !w_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (state == S_RUN && in_ready && !in_valid && starve_cycles != '1)
                starve_cycles <= starve_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_tile_packer.sv
// tb/tb_weight_tile_packer.sv - randomized self-checking bench for weight_tile_packer
module tb_weight_tile_packer;
    localparam int DW = 8, TS = 32, IB = 8, DIMW = 10, TW = TS * DW;

    logic                 clk = 1'b0;
    logic                 rst, start, in_valid, in_ready, w_valid, w_ready, busy, done;
    logic [DIMW-1:0]      rows, cols;
    logic [IB*DW-1:0]     in_data;
    logic signed [DW-1:0] w_tile [0:TS-1];
    int                   checks = 0;
    int                   failures = 0;

    always #5 clk = ~clk;

    weight_tile_packer #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .IN_BYTES(IB), .DIM_WIDTH(DIMW)) dut (
        .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_tile(w_tile),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] tile_vec();
        logic [TW-1:0] v;
        for (int i = 0; i < TS; i++) v[i*DW +: DW] = w_tile[i];
        return v;
    endfunction

    // seq=1: element j carries base+j; otherwise random bytes.
    task automatic run_matrix(input int r, input int c, input bit seq, input int base,
                              input int vpct, input int rpct, input int hold, input int abort_at,
                              input bit chk_lat, input bit chk_b2b);
        logic [7:0]    elems[$];
        logic [TW-1:0] exp_q[$];
        logic [TW-1:0] tv, prev_tv, ev;
        int            hs[$];
        int total = r * c;
        int nb    = (total + IB - 1) / IB;
        int tpr   = (c + TS - 1) / TS;
        int beat_idx = 0, seen = 0, first_wv = -1;
        bit got_done = 0, stall_prev = 0;

        for (int j = 0; j < nb * IB; j++)
            elems.push_back(seq ? 8'(base + j) : 8'($urandom));
        for (int rr = 0; rr < r; rr++)
            for (int t = 0; t < tpr; t++) begin
                ev = '0;
                for (int i = 0; i < TS; i++)
                    if (t * TS + i < c) ev[i*DW +: DW] = elems[rr * c + t * TS + i];
                exp_q.push_back(ev);
            end

        @(posedge clk); #1;
        start = 1'b1; rows = DIMW'(r); cols = DIMW'(c); in_valid = 1'b0; w_ready = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) return;
            start = 1'b0;
            if (beat_idx < nb) begin
                in_valid = ($urandom_range(99) < vpct);
                for (int j = 0; j < IB; j++) in_data[j*DW +: DW] = elems[beat_idx * IB + j];
            end else begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom};
            end
            w_ready = (k < hold) ? 1'b0 : ($urandom_range(99) < rpct);
            @(negedge clk);
            tv = tile_vec();
            if (k == 0 && total != 0) check("busy_after_start", busy, 1'b1);
            if (stall_prev) begin
                check("stall_w_valid", w_valid, 1'b1);
                check("stall_tile_stable", tv, prev_tv);
            end
            stall_prev = w_valid && !w_ready;
            prev_tv = tv;
            if (w_valid && first_wv < 0) first_wv = k;
            if (beat_idx >= nb && in_valid) check("in_ready_exhausted", in_ready, 1'b0);
            else if (in_valid && in_ready) beat_idx++;
            if (hold > 0 && k == hold - 1) begin
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_w_valid", w_valid, 1'b1);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) check("tile_extra", 1, 0);
                else check($sformatf("tile%0d_r%0d_c%0d", seen, r, c), tv, exp_q.pop_front());
                seen++;
                hs.push_back(k);
            end
            if (done) begin
                got_done = 1;
                check("busy_at_done", busy, 1'b0);
                check("w_valid_at_done", w_valid, 1'b0);
                break;
            end
        end
        check("done_seen", got_done, 1'b1);
        check("tile_count", seen, r * tpr);
        check("beats_used", beat_idx, nb);
        if (chk_lat) check("first_tile_latency", first_wv, 5);
        if (chk_b2b) check("b2b_after_stall", (hs.size() >= 2) ? hs[1] - hs[0] : -1, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; w_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; w_ready = 1'b0;
        rows = '0; cols = '0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tile", tile_vec(), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_matrix(1, 32, 1, 0, 100, 100, 0, -1, 1, 0);
        run_matrix(2, 20, 1, 1, 100, 100, 0, -1, 0, 0);
        run_matrix(1, 70, 0, 0, 100, 100, 0, -1, 0, 0);
        run_matrix(3, 32, 0, 0, 100, 100, 20, -1, 0, 1);
        run_matrix(0, 5, 0, 0, 100, 100, 0, -1, 0, 0);

        run_matrix(4, 64, 0, 0, 100, 0, 0, 10, 0, 0);
        #2;
        check("pre_reset_w_valid", w_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_w_valid", w_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_tile", tile_vec(), '0);
        start = 1'b0; in_valid = 1'b0; w_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_matrix(1, 8, 1, 100, 100, 100, 0, -1, 0, 0);

        run_matrix(2, 64, 0, 0, 70, 60, 0, -1, 0, 0);
        run_matrix(3, 1, 0, 0, 80, 80, 0, -1, 0, 0);
        for (int t = 0; t < 6; t++)
            run_matrix($urandom_range(1, 5), $urandom_range(1, 100), 0, 0,
                       $urandom_range(30, 100), $urandom_range(30, 100), 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
